// File: rtl/digit_alu_pkg.sv
// Shared definitions for the digit-serial ALU: op encodings, FSM states, digit width.
package digit_alu_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_DADD = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_LG2  = 3'd5,
        OP_RSVD = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/digit_slice.sv
// Combinational single-digit stage: one 4-bit digit of any op, with carry in/out and fault flag.
module digit_slice
    import digit_alu_pkg::*;
(
    input  op_e                op,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] dout,
    output logic               cout,
    output logic               err
);

    logic [DIGIT_W:0] sum_ab;
    logic [DIGIT_W:0] sum_sub;

    assign sum_ab  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};

    always_comb begin
        dout = a;
        cout = cin;
        err  = 1'b0;
        case (op)
            OP_ADD:  {cout, dout} = sum_ab;
            OP_SUB:  {cout, dout} = sum_sub;
            OP_DADD: begin
                // Decimal correction: wrapping s+6 in 4 bits yields s-10.
                if (sum_ab > 5'd9) begin
                    dout = sum_ab[3:0] + 4'd6;
                    cout = 1'b1;
                end else begin
                    dout = sum_ab[3:0];
                    cout = 1'b0;
                end
            end
            OP_ROL: begin
                dout = {a[2:0], cin};
                cout = a[3];
            end
            OP_ROR: begin
                dout = {cin, a[3:1]};
                cout = a[0];
            end
            OP_LG2: begin
                case (a)
                    4'h0:    dout = 4'h0;
                    4'h1:    dout = 4'h1;
                    4'h2:    dout = 4'h2;
                    4'h4:    dout = 4'h3;
                    4'h8:    dout = 4'h4;
                    default: begin
                        dout = 4'hF;
                        err  = 1'b1;
                    end
                endcase
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/digit_serial_alu.sv
// Multi-digit ALU processing one 4-bit digit per cycle with a carry chain between digits.
module digit_serial_alu
    import digit_alu_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic                    carry_in,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     result,
    output logic                    carry_out,
    output logic                    error
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e             state_reg, state_next;
    op_e                op_reg;
    logic [W-1:0]       a_reg, b_reg, work_reg, work_next;
    logic [IDX_W-1:0]   cnt_reg, idx;
    logic               c_reg, err_acc_reg;
    logic [W-1:0]       result_reg;
    logic               carry_out_reg, error_reg;

    logic [DIGIT_W-1:0] slice_a, slice_b, slice_dout;
    logic               slice_cout, slice_err, last_digit;

    // ROR walks the word MSD first so the carry enters at the top digit.
    assign idx        = (op_reg == OP_ROR) ? (LAST_IDX - cnt_reg) : cnt_reg;
    assign last_digit = (cnt_reg == LAST_IDX);
    assign slice_a    = a_reg[{idx, 2'b00} +: DIGIT_W];
    assign slice_b    = b_reg[{idx, 2'b00} +: DIGIT_W];

    digit_slice u_slice (
        .op   (op_reg),
        .a    (slice_a),
        .b    (slice_b),
        .cin  (c_reg),
        .dout (slice_dout),
        .cout (slice_cout),
        .err  (slice_err)
    );

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_work
        assign work_next[gi*DIGIT_W +: DIGIT_W] =
            (idx == IDX_W'(gi)) ? slice_dout : work_reg[gi*DIGIT_W +: DIGIT_W];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_digit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_ADD;
            a_reg         <= '0;
            b_reg         <= '0;
            work_reg      <= '0;
            cnt_reg       <= '0;
            c_reg         <= 1'b0;
            err_acc_reg   <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (start) begin
                    op_reg      <= op_e'(op);
                    a_reg       <= a;
                    b_reg       <= b;
                    work_reg    <= '0;
                    cnt_reg     <= '0;
                    c_reg       <= (op_e'(op) == OP_SUB) ? ~carry_in : carry_in;
                    err_acc_reg <= 1'b0;
                end
                ST_RUN: begin
                    work_reg    <= work_next;
                    c_reg       <= slice_cout;
                    err_acc_reg <= err_acc_reg | slice_err;
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (last_digit) begin
                        result_reg    <= work_next;
                        carry_out_reg <= slice_cout;
                        error_reg     <= err_acc_reg | slice_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign error     = error_reg;

endmodule

// File: doc/digit_serial_alu.md
Name: digit_serial_alu

Overview:
Multi-digit arithmetic unit for the 4-bit CPU datapath. It processes a DIGITS-wide operand one 4-bit digit per cycle, chaining carry between digits. It replaces software loops for multi-digit binary/decimal add, subtract, whole-word rotate-through-carry and per-digit log2+1. It sits beside the single-digit datapath ALU, driven by a start/busy/done handshake from the instruction sequencer.

Parameters:
DIGITS, 4, number of 4-bit digits per operand (legal 1..16); operand width is 4*DIGITS.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request an operation; accepted only when busy=0
op  input  3  operation select, sampled with start
carry_in  input  1  carry flag, sampled with start
a  input  4*DIGITS  operand A, digit 0 = bits [3:0]
b  input  4*DIGITS  operand B
busy  output  1  high from the cycle after acceptance through the done cycle
done  output  1  one-cycle pulse; result/carry_out/error valid from this cycle
result  output  4*DIGITS  registered result, held until next done
carry_out  output  1  final carry, held
error  output  1  sticky-per-operation fault flag, held

Behaviour:
- Interface: single clock `clock`; `reset` synchronous, active-high.
- Reset: state IDLE; busy=0, done=0, result=0, carry_out=0, error=0; working registers cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM: IDLE -> RUN on start&&!busy; RUN lasts exactly DIGITS cycles, one digit per edge; RUN -> DONE; DONE -> IDLE after one cycle.
- Latency: start high in cycle 0 -> busy high cycles 1..DIGITS+1; done high in cycle DIGITS+1. The earliest next accept is cycle DIGITS+2.
- a, b, op and carry_in are latched at acceptance. Later input changes do not affect the operation. start while busy is ignored, with no queueing.
- Digit order: LSD first (0..DIGITS-1) for all ops except ROR, which runs MSD first (DIGITS-1..0).
- Carry chain c is initialised at acceptance and updated every RUN cycle. carry_out = final c.
- op 0 ADD: s = a_i + b_i + c (5-bit); digit = s[3:0]; c = s[4]; c0 = carry_in.
- op 1 SUB: s = a_i + ~b_i + c; c0 = ~carry_in. carry_out=1 means no borrow.
- op 2 DADD: s = a_i + b_i + c. If s>9: digit = (s+6)[3:0], c=1. Otherwise digit = s, c=0. c0 = carry_in. Non-BCD inputs are not flagged.
- op 3 ROL: digit = {a_i[2:0], c}; c = a_i[3]; c0 = carry_in. The whole word rotates left through carry.
- op 4 ROR: digit = {c, a_i[3:1]}; c = a_i[0]; c0 = carry_in. The whole word rotates right through carry.
- op 5 LG2: mapping 0->0, 1->1, 2->2, 4->3, 8->4, other->F. error is set if any digit maps to F. carry_out = carry_in.
- ops 6,7 reserved: result = a, carry_out = carry_in, error = 1. The op still takes DIGITS+1 cycles.
- result, carry_out and error update only on the edge entering DONE. They hold through IDLE and the following RUN.

Decomposition:
- Package digit_alu_pkg: op encodings (OP_ADD..OP_LG2, OP_RSVD), FSM state encoding, digit width constant 4.
- One combinational sub-module, digit_slice. Inputs: op, a digit, b digit, cin. Outputs: digit out, cout, err. It is instantiated once.
- Top level: FSM, digit index counter (up or down), working result shift/indexed register, carry and error registers.

Test Plan:
- DIGITS=4, DADD, a=0x0958, b=0x0047, carry_in=0 -> result=0x1005, carry_out=0, error=0; done exactly in cycle 5.
- SUB, carry_in=0: a=0x1234, b=0x0235 -> 0x0FFF, carry_out=1. Then a=0x0001, b=0x0002 -> 0xFFFF, carry_out=0.
- ROL, a=0x8001, carry_in=1 -> 0x0003, carry_out=1. ROR, a=0x8001, carry_in=0 -> 0x4000, carry_out=1.
- LG2, a=0x8421 -> 0x4321, error=0. a=0x0300 -> 0x0F00, error=1. Then ADD 0x0001+0x0001 -> error returns to 0.
- ADD accepted in cycle 0; a second start with different operands in cycle 2 is ignored. Its result reflects the first operands only. Reset in cycle 3 of another op -> busy=0 next cycle, result=0, no done pulse.
- DIGITS=1 build: ADD a=0xF, b=0x1, carry_in=0 -> result=0x0, carry_out=1, done in cycle 2. op=6 -> result=a, error=1.
